// File: rtl/simple_register.sv
// rtl/simple_register.sv - parallel-load datapath register, reloads every cycle
// Holds instruction, memory-data and ALU-out values between multi-cycle steps.
module simple_register #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] input_SR,
    output logic [WIDTH-1:0] output_SR
);

    // Declaration initializer gives a defined power-up value before the first edge.
    logic [WIDTH-1:0] data_q = RESET_VALUE;

    // X/Z on RST falls through to the load branch, so an unconnected RST acts as a plain register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= input_SR;
        end
    end

    assign output_SR = data_q;

endmodule

// File: tb/tb_simple_register.sv
// tb/tb_simple_register.sv - directed self-checking bench for simple_register
module tb_simple_register;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] input_SR = 16'h0000;
    logic [15:0] output_SR;

    int checks = 0;
    int failures = 0;

    simple_register #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .input_SR  (input_SR),
        .output_SR (output_SR)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        #1;
        checks++;
        if (output_SR !== 16'h0000) begin
            failures++;
            $display("FAIL power_up_value actual=%h expected=%h", output_SR, 16'h0000);
        end
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h0000) begin
            failures++;
            $display("FAIL first_edge_zero actual=%h expected=%h", output_SR, 16'h0000);
        end
        RST = 1'b1;
        input_SR = 16'h1111;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h0000) begin
            failures++;
            $display("FAIL explicit_reset actual=%h expected=%h", output_SR, 16'h0000);
        end
        RST = 1'b0;
    endtask

    task automatic test_capture_between_edges();
        input_SR = 16'hABCD;
        #2;
        checks++;
        if (output_SR !== 16'h0000) begin
            failures++;
            $display("FAIL hold_before_edge actual=%h expected=%h", output_SR, 16'h0000);
        end
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'hABCD) begin
            failures++;
            $display("FAIL capture_abcd actual=%h expected=%h", output_SR, 16'hABCD);
        end
    endtask

    task automatic test_last_value_wins();
        input_SR = 16'h1111;
        #1;
        input_SR = 16'h2222;
        #1;
        input_SR = 16'h3333;
        #1;
        checks++;
        if (output_SR !== 16'hABCD) begin
            failures++;
            $display("FAIL no_comb_path actual=%h expected=%h", output_SR, 16'hABCD);
        end
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h3333) begin
            failures++;
            $display("FAIL last_value_wins actual=%h expected=%h", output_SR, 16'h3333);
        end
    endtask

    task automatic test_back_to_back();
        input_SR = 16'h1234;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h1234) begin
            failures++;
            $display("FAIL b2b_first actual=%h expected=%h", output_SR, 16'h1234);
        end
        input_SR = 16'h5678;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h5678) begin
            failures++;
            $display("FAIL b2b_second actual=%h expected=%h", output_SR, 16'h5678);
        end
    endtask

    task automatic test_reset_priority();
        RST = 1'b1;
        input_SR = 16'hFFFF;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h0000) begin
            failures++;
            $display("FAIL reset_wins actual=%h expected=%h", output_SR, 16'h0000);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'hFFFF) begin
            failures++;
            $display("FAIL load_after_reset actual=%h expected=%h", output_SR, 16'hFFFF);
        end
    endtask

    task automatic test_reset_hold();
        logic [15:0] pattern [3];
        pattern[0] = 16'hAAAA;
        pattern[1] = 16'h5555;
        pattern[2] = 16'hAAAA;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input_SR = pattern[i];
            @(negedge CLK);
            checks++;
            if (output_SR !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold_%0d actual=%h expected=%h", i, output_SR, 16'h0000);
            end
        end
        RST = 1'b0;
        input_SR = 16'h5555;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h5555) begin
            failures++;
            $display("FAIL release_after_hold actual=%h expected=%h", output_SR, 16'h5555);
        end
    endtask

    task automatic test_walking_ones();
        logic [15:0] expected;
        for (int i = 0; i < 16; i++) begin
            expected = 16'h0001 << i;
            input_SR = expected;
            @(negedge CLK);
            checks++;
            if (output_SR !== expected) begin
                failures++;
                $display("FAIL walking_one_bit%0d actual=%h expected=%h", i, output_SR, expected);
            end
        end
    endtask

    task automatic test_reset_z();
        RST = 1'bz;
        input_SR = 16'h8001;
        @(negedge CLK);
        checks++;
        if (output_SR !== 16'h8001) begin
            failures++;
            $display("FAIL rst_floating actual=%h expected=%h", output_SR, 16'h8001);
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture_between_edges();
        test_last_value_wins();
        test_back_to_back();
        test_reset_priority();
        test_reset_hold();
        test_walking_ones();
        test_reset_z();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_register.md
# simple_register

Clocked, parallel-load data register with synchronous reset, used in the 16-bit multi-cycle datapath. It holds values such as instruction, memory-data and ALU-out between cycle steps. It captures `input_SR` on every rising edge of `CLK` and presents the stored value on `output_SR` until the next edge. It has no load enable: it reloads every cycle.

## Interface
- `WIDTH`, default 16: data width in bits.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: value loaded by reset. Also the simulation power-up value.
- `CLK`  input  1: rising-edge clock, the only clock.
- `RST`  input  1: reset, synchronous and active-high.
- `input_SR`  input  WIDTH: data to capture.
- `output_SR`  output  WIDTH: registered data, driven directly from the storage flops.

## Operation
- On each rising edge of `CLK`:
  - If `RST == 1`: the register is set to `RESET_VALUE`.
  - Otherwise: the register is set to `input_SR`.
- `output_SR` always equals the register contents. There is no combinational path from `input_SR` to `output_SR`.
- Reset has priority over the data load in the same cycle.
- `RST` is evaluated with `if (RST)` semantics, so X or Z on `RST` counts as deasserted. An instance with `RST` left unconnected behaves as a plain register.
- Between edges, changes on `input_SR` have no effect on `output_SR`.
- Multiple `input_SR` changes within one clock period: only the value present at the rising edge is captured. Earlier values are lost.
- Width rule: the full WIDTH bits are stored with no truncation, sign handling or arithmetic.
- The register is initialized to `RESET_VALUE` at time 0 for simulation, so `output_SR` is never X before the first edge.

## Timing
- Latency is 1 cycle: a value on `input_SR` that is stable at rising edge N appears on `output_SR` immediately after edge N and holds until edge N+1.
- Reset:
  - Asserting `RST` across edge N gives `output_SR == RESET_VALUE` after edge N.
  - Deasserting `RST` before edge N+1 loads `input_SR` at edge N+1.
- Reset mid-operation: the value held before reset is discarded at the reset edge. There is no recovery of it.
- Reset value of the only output: `output_SR = RESET_VALUE` (0x0000 by default).
- Setup and hold are relative to the `CLK` rising edge only. Stimulus in the bench changes on the falling edge.

## Test plan
- Power-up, `RST` low, `input_SR = 0x0000` -> after the first rising edge, `output_SR == 0x0000`.
- `input_SR = 0xABCD` applied between edges -> `output_SR` still holds the old value before the next rising edge, and reads 0xABCD after it.
- `input_SR = 0x1234`, then `input_SR = 0x5678` on the following falling edge -> `output_SR` reads 0x1234 for exactly one cycle, then 0x5678.
- `output_SR == 0x5678`, `RST = 1` for one edge with `input_SR = 0xFFFF` -> `output_SR == 0x0000` (reset wins). Then `RST = 0` -> `output_SR == 0xFFFF` after the next edge.
- `RST` held high for 3 edges while `input_SR` toggles 0xAAAA/0x5555 -> `output_SR` stays 0x0000 throughout.
- `RST` left unconnected (Z), `input_SR = 0x8001` -> `output_SR == 0x8001` after one edge.
